// File: rtl/pipeline_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
// Shared definitions for the MIPS32 pipeline hazard controller:
//   hz_state_e  FSM state codes (RUN=0, LOAD_STALL=1, MEM_WAIT=2; code 3 unused)
//   REG_ZERO    register $zero, which can never create a load-use dependency
// -----------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_RUN        = 2'd0,
        HZ_LOAD_STALL = 2'd1,
        HZ_MEM_WAIT   = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_hazard_detect
// Combinational load-use detector. Flags when the LW currently in EX writes a
// register that the instruction in ID is about to read.
// Ports:
//   id_rs, id_rt   in  source registers of the ID instruction
//   id_uses_rt     in  ID instruction actually reads rt
//   ex_mem_read    in  EX instruction is a load
//   ex_rt          in  load destination register
//   load_use       out dependency present, ID must wait one cycle
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl_hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       load_use
);

    // $zero is hardwired, so a load "into" it never produces a value to wait on.
    assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Sequences the 5-stage MIPS32 pipeline: load-use stalls, taken-branch/jump
// flushes and multi-cycle data-memory waits with a timeout. Outputs are Mealy
// (combinational from state and inputs); state, wait counter, sticky error and
// optional performance counters are registered with an async active-high reset.
//
// Optional feature: define HZ_PERF_CNT_EN to implement stall_cycles and
// flush_count; otherwise those ports are tied to zero and no counter flops exist.
//
// Ports:
//   clock, reset            clock (rising edge), asynchronous active-high reset
//   id_rs, id_rt, id_uses_rt  ID-stage source register info
//   ex_mem_read, ex_rt      LW in EX and its destination
//   ex_redirect             EX resolved a taken branch / J / JAL / JR
//   mem_req, mem_ready      dmem access in progress / completing this cycle
//   pc_write, if_id_write   PC and IF/ID load enables
//   if_id_flush             IF/ID loads NOP
//   id_ex_bubble            ID/EX loads NOP
//   ex_mem_hold             EX/MEM and ID/EX hold
//   mem_wb_bubble           MEM/WB loads NOP
//   mem_error               sticky dmem timeout flag
//   hz_state                current FSM state (debug)
//   stall_cycles            cycles with pc_write=0 (saturating)
//   flush_count             redirect flushes taken (saturating)
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int PERF_W      = 32
)(
    input  logic              clock,
    input  logic              reset,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rt,
    input  logic              ex_redirect,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              ex_mem_hold,
    output logic              mem_wb_bubble,
    output logic              mem_error,
    output logic [1:0]        hz_state,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_count
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_e          state, state_nxt;
    logic [CNT_W-1:0]   wait_cnt, cnt_nxt;
    logic               err_set;
    logic               load_use;
    logic               mem_done;

    pipeline_hazard_ctrl_hazard_detect u_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .load_use    (load_use)
    );

    // A ready strobe only counts when an access is actually outstanding.
    assign mem_done = mem_req && mem_ready;

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_hold   = 1'b0;
        mem_wb_bubble = 1'b0;
        state_nxt     = state;
        cnt_nxt       = wait_cnt;
        err_set       = 1'b0;

        case (state)
            HZ_RUN, HZ_LOAD_STALL: begin
                if (mem_req && !mem_ready) begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    ex_mem_hold   = 1'b1;
                    mem_wb_bubble = 1'b1;
                    state_nxt     = HZ_MEM_WAIT;
                    cnt_nxt       = CNT_W'(1);
                end else if (ex_redirect) begin
                    // Redirect wins over load-use: the dependent instruction is squashed anyway.
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    state_nxt    = HZ_RUN;
                end else if (load_use && (state == HZ_RUN)) begin
                    // In LOAD_STALL the bubble already separated the pair, so no re-trigger.
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    state_nxt    = HZ_LOAD_STALL;
                end else begin
                    state_nxt = HZ_RUN;
                end
            end

            HZ_MEM_WAIT: begin
                if (mem_done || (wait_cnt == CNT_W'(MEM_TIMEOUT))) begin
                    // Pipeline advances: either the access finished or it is abandoned.
                    // Any redirect or load-use held behind the freeze is handled now.
                    cnt_nxt = '0;
                    if (!mem_done) begin
                        err_set       = 1'b1;
                        mem_wb_bubble = 1'b1;
                    end
                    if (ex_redirect) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        state_nxt    = HZ_RUN;
                    end else if (load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        state_nxt    = HZ_LOAD_STALL;
                    end else begin
                        state_nxt = HZ_RUN;
                    end
                end else begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    ex_mem_hold   = 1'b1;
                    mem_wb_bubble = 1'b1;
                    cnt_nxt       = wait_cnt + CNT_W'(1);
                end
            end

            default: begin
                state_nxt = HZ_RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= HZ_RUN;
            wait_cnt  <= '0;
            mem_error <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= cnt_nxt;
            if (err_set) begin
                mem_error <= 1'b1;
            end
        end
    end

    assign hz_state = state;

`ifdef HZ_PERF_CNT_EN
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + PERF_W'(1);
    endfunction

    logic [PERF_W-1:0] stall_q, flush_q;

    // A flush is taken exactly when if_id_flush is asserted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write) begin
                stall_q <= sat_inc(stall_q);
            end
            if (if_id_flush) begin
                flush_q <= sat_inc(flush_q);
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int MEM_TIMEOUT = 15;
    localparam int PERF_W      = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic [4:0]        id_rs, id_rt, ex_rt;
    logic              id_uses_rt, ex_mem_read, ex_redirect, mem_req, mem_ready;
    logic              pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic              ex_mem_hold, mem_wb_bubble, mem_error;
    logic [1:0]        hz_state;
    logic [PERF_W-1:0] stall_cycles, flush_count;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .PERF_W(PERF_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .ex_mem_read   (ex_mem_read),
        .ex_rt         (ex_rt),
        .ex_redirect   (ex_redirect),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .if_id_flush   (if_id_flush),
        .id_ex_bubble  (id_ex_bubble),
        .ex_mem_hold   (ex_mem_hold),
        .mem_wb_bubble (mem_wb_bubble),
        .mem_error     (mem_error),
        .hz_state      (hz_state),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: how many frozen cycles the current dmem access has used
    // (0 = no access pending), whether last cycle was a load-use stall, and the
    // running totals of stalls and flushes.
    int     m_frozen;
    bit     m_stalled;
    bit     m_err;
    longint m_stalls, m_flushes;
    longint perf_max;

    task automatic m_reset();
        m_frozen  = 0;
        m_stalled = 0;
        m_err     = 0;
        m_stalls  = 0;
        m_flushes = 0;
    endtask

    function automatic longint exp_perf(input longint v);
`ifdef HZ_PERF_CNT_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic drive_idle();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_mem_read = 0; ex_rt = 0;
        ex_redirect = 0; mem_req = 0; mem_ready = 0;
    endtask

    // One clock cycle: drive inputs after the falling edge, compare the DUT
    // against the model, then advance the model to what the next edge does.
    task automatic cyc(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic mr, input logic [4:0] ert, input logic redir,
                       input logic req, input logic rdy);
        bit lu, done, advance, allow_lu, set_err, n_stalled;
        int n_frozen, e_state;
        logic [5:0] e_outs, outs;
        @(negedge clock);
        id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_mem_read = mr; ex_rt = ert;
        ex_redirect = redir; mem_req = req; mem_ready = rdy;
        #1;
        lu   = mr && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));
        done = req && rdy;
        e_state   = (m_frozen > 0) ? 2 : (m_stalled ? 1 : 0);
        e_outs    = 6'b110000; // {pc_write, if_id_write, flush, bubble, hold, wb_bubble}
        n_frozen  = 0;
        n_stalled = 0;
        set_err   = 0;
        advance   = 1;
        allow_lu  = 1;
        if (m_frozen > 0) begin
            if (!done && m_frozen < MEM_TIMEOUT) begin
                e_outs   = 6'b000011;
                n_frozen = m_frozen + 1;
                advance  = 0;
            end else if (!done) begin
                set_err   = 1;
                e_outs[0] = 1'b1;
            end
        end else if (req && !rdy) begin
            e_outs   = 6'b000011;
            n_frozen = 1;
            advance  = 0;
        end else begin
            allow_lu = !m_stalled;
        end
        if (advance) begin
            if (redir) begin
                e_outs[3] = 1'b1;
                e_outs[2] = 1'b1;
            end else if (lu && allow_lu) begin
                e_outs[5]  = 1'b0;
                e_outs[4]  = 1'b0;
                e_outs[2]  = 1'b1;
                n_stalled  = 1;
            end
        end
        outs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold, mem_wb_bubble};
        chk("outs", 64'(outs), 64'(e_outs));
        chk("hz_state", 64'(hz_state), 64'(e_state));
        chk("mem_error", 64'(mem_error), 64'(m_err));
        chk("stall_cycles", 64'(stall_cycles), 64'(exp_perf(m_stalls)));
        chk("flush_count", 64'(flush_count), 64'(exp_perf(m_flushes)));
        if (!e_outs[5] && m_stalls < perf_max) m_stalls++;
        if (e_outs[3] && m_flushes < perf_max) m_flushes++;
        if (set_err) m_err = 1;
        m_frozen  = n_frozen;
        m_stalled = n_stalled;
    endtask

    initial begin
        perf_max = (64'sd1 <<< PERF_W) - 1;
        drive_idle();
        reset = 1'b1;
        m_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_pc_write", 64'(pc_write), 64'(1));
        chk("rst_if_id_write", 64'(if_id_write), 64'(1));
        chk("rst_state", 64'(hz_state), 64'(0));
        chk("rst_mem_error", 64'(mem_error), 64'(0));
        chk("rst_stall_cycles", 64'(stall_cycles), 64'(0));
        reset = 1'b0;

        // LW $t0 in EX, ID reads rs=$t0: one stall cycle then back to RUN.
        cyc(8, 0, 0, 1, 8, 0, 0, 0);
        chk("lu_pc_write", 64'(pc_write), 64'(0));
        chk("lu_bubble", 64'(id_ex_bubble), 64'(1));
        cyc(8, 0, 0, 1, 8, 0, 0, 0);
        chk("lu_stall_state", 64'(hz_state), 64'(1));
        chk("lu_no_retrigger", 64'(pc_write), 64'(1));
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lu_back_run", 64'(hz_state), 64'(0));

        // No stall: load to $zero, and rt match when rt not read.
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        chk("zero_no_stall", 64'(pc_write), 64'(1));
        cyc(1, 9, 0, 1, 9, 0, 0, 0);
        chk("rt_unused_no_stall", 64'(pc_write), 64'(1));
        cyc(1, 9, 1, 1, 9, 0, 0, 0);
        chk("rt_used_stall", 64'(pc_write), 64'(0));
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // Redirect beats load-use.
        cyc(8, 0, 0, 1, 8, 1, 0, 0);
        chk("redir_flush", 64'(if_id_flush), 64'(1));
        chk("redir_bubble", 64'(id_ex_bubble), 64'(1));
        chk("redir_pc_write", 64'(pc_write), 64'(1));
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("redir_state_run", 64'(hz_state), 64'(0));

        // dmem ready after 4 frozen cycles.
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 1, 0);
            chk("wait_frozen", 64'(pc_write), 64'(0));
        end
        chk("wait_state", 64'(hz_state), 64'(2));
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        chk("ready_advance", 64'(pc_write), 64'(1));
        chk("ready_no_hold", 64'(ex_mem_hold), 64'(0));
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("ready_state_run", 64'(hz_state), 64'(0));

        // dmem never ready: 15 frozen cycles, then abandon with error.
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 1, 0);
        end
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("timeout_advance", 64'(pc_write), 64'(1));
        chk("timeout_wb_bubble", 64'(mem_wb_bubble), 64'(1));
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("timeout_error", 64'(mem_error), 64'(1));
        chk("timeout_state_run", 64'(hz_state), 64'(0));

        // Reset in the middle of a wait acts immediately.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 1, 0);
        end
        #2;
        drive_idle();
        reset = 1'b1;
        #1;
        chk("midrst_state", 64'(hz_state), 64'(0));
        chk("midrst_pc_write", 64'(pc_write), 64'(1));
        chk("midrst_hold", 64'(ex_mem_hold), 64'(0));
        chk("midrst_mem_error", 64'(mem_error), 64'(0));
        chk("midrst_stall_cycles", 64'(stall_cycles), 64'(0));
        chk("midrst_flush_count", 64'(flush_count), 64'(0));
        m_reset();
        @(negedge clock);
        reset = 1'b0;

        // Randomized traffic with small register numbers so hazards are common.
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] rs, rt, ert;
            logic urt, mr, redir, req, rdy;
            rs    = 5'($urandom_range(0, 3));
            rt    = 5'($urandom_range(0, 3));
            ert   = 5'($urandom_range(0, 3));
            urt   = 1'($urandom_range(0, 1));
            mr    = ($urandom_range(0, 99) < 50);
            redir = ($urandom_range(0, 99) < 15);
            req   = ($urandom_range(0, 99) < 25);
            rdy   = ($urandom_range(0, 99) < 12);
            cyc(rs, rt, urt, mr, ert, redir, req, rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
